// File: rtl/dist_euclid_axil_slave.sv
// dist_euclid_axil_slave: AXI4-Lite register front end for the Euclidean-distance engine.
// Holds two signed 16-bit points, runs a shared-multiplier squared-distance pipeline on START,
// and exposes CTRL status, RESULT and a level interrupt (DONE & IE).
// Optional feature macro DIST_SQRT_EN: replaces the saturating write-back with a 17-step
// restoring integer square root, so RESULT holds floor(sqrt(dx^2 + dy^2)) and OVF never sets.
module dist_euclid_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic                              irq
);

   typedef enum logic [2:0] {IDLE, SUB, SQX, SQY, WB, SQRT} state_e;

   state_e       state_q, state_d;
   logic         awReady_q, bValid_q, arReady_q, rValid_q;
   logic [31:0]  rData_q, rData_d;
   logic [31:0]  pa_q, pb_q, snapA_q, snapB_q, result_q;
   logic         done_q, ovf_q, ie_q;
   logic [16:0]  dx_q, dy_q;
   logic [31:0]  sqX_q;
   logic         busy, mulSelY;
   logic         wrAccept, wrFire, rdAccept, rdFire;
   logic [1:0]   wrSel;
   logic         startReq, doneClr;
   logic [16:0]  mulIn;
   logic signed [33:0] mulExt, prodFull;
   logic [31:0]  sqr;
   logic [32:0]  sumNext;
   logic         unusedBits;

`ifdef DIST_SQRT_EN
   logic [33:0]  rad_q;
   logic [19:0]  rem_q, remShift, trial, remNext;
   logic [16:0]  root_q, rootNext;
   logic [4:0]   cnt_q;
   logic         remGe;
   logic         unusedSqrt;
`else
   logic [32:0]  sum_q;
`endif

   assign unusedBits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                         s00_axi_araddr[1:0], prodFull[33:32]};

   // Handshake qualifiers: ready pulses one cycle after the request, transfer fires while ready is high
   assign wrAccept = s00_axi_awvalid & s00_axi_wvalid & ~bValid_q & ~awReady_q;
   assign wrFire   = awReady_q & s00_axi_awvalid & s00_axi_wvalid;
   assign rdAccept = s00_axi_arvalid & ~rValid_q & ~arReady_q;
   assign rdFire   = arReady_q & s00_axi_arvalid;
   assign wrSel    = s00_axi_awaddr[3:2];

   assign startReq = wrFire & (wrSel == 2'd2) & s00_axi_wstrb[0] & s00_axi_wdata[0] & ~busy;
   assign doneClr  = wrFire & (wrSel == 2'd2) & s00_axi_wstrb[0] & s00_axi_wdata[1];

   assign s00_axi_awready = awReady_q;
   assign s00_axi_wready  = awReady_q;
   assign s00_axi_bvalid  = bValid_q;
   assign s00_axi_bresp   = 2'b00;
   assign s00_axi_arready = arReady_q;
   assign s00_axi_rvalid  = rValid_q;
   assign s00_axi_rdata   = rData_q;
   assign s00_axi_rresp   = 2'b00;
   assign irq             = done_q & ie_q;

   // Single shared squarer: dx during SQX, dy during SQY
   assign mulIn    = mulSelY ? dy_q : dx_q;
   assign mulExt   = {{17{mulIn[16]}}, mulIn};
   assign prodFull = mulExt * mulExt;
   assign sqr      = prodFull[31:0];
   assign sumNext  = {1'b0, sqX_q} + {1'b0, sqr};

`ifdef DIST_SQRT_EN
   assign remShift   = {rem_q[17:0], rad_q[33:32]};
   assign trial      = {1'b0, root_q, 2'b01};
   assign remGe      = (remShift >= trial);
   assign remNext    = remGe ? (remShift - trial) : remShift;
   assign rootNext   = {root_q[15:0], remGe};
   assign unusedSqrt = ^{rem_q[19:18], root_q[16]};
`endif

   // Register read mux; values are sampled before any same-edge write lands
   always_comb begin
      rData_d = 32'd0;
      case (s00_axi_araddr[3:2])
         2'd0:    rData_d = pa_q;
         2'd1:    rData_d = pb_q;
         2'd2:    rData_d = {27'd0, ie_q, ovf_q, busy, done_q, 1'b0};
         default: rData_d = result_q;
      endcase
   end

   // AXI channel handshake registers
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         awReady_q <= 1'b0;
         bValid_q  <= 1'b0;
         arReady_q <= 1'b0;
         rValid_q  <= 1'b0;
         rData_q   <= 32'd0;
      end else begin
         awReady_q <= wrAccept;
         arReady_q <= rdAccept;
         if (wrFire)
            bValid_q <= 1'b1;
         else if (s00_axi_bready)
            bValid_q <= 1'b0;
         if (rdFire) begin
            rValid_q <= 1'b1;
            rData_q  <= rData_d;
         end else if (s00_axi_rready) begin
            rValid_q <= 1'b0;
         end
      end
   end

   // Point registers (byte strobes honoured) and interrupt enable
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         pa_q <= 32'd0;
         pb_q <= 32'd0;
         ie_q <= 1'b0;
      end else if (wrFire) begin
         for (int b = 0; b < 4; b++) begin
            if (s00_axi_wstrb[b] && wrSel == 2'd0) pa_q[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            if (s00_axi_wstrb[b] && wrSel == 2'd1) pb_q[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
         end
         if (wrSel == 2'd2 && s00_axi_wstrb[0]) ie_q <= s00_axi_wdata[4];
      end
   end

   // FSM state register
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) state_q <= IDLE;
      else                  state_q <= state_d;
   end

   // FSM next state: one cycle per datapath step
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (startReq) state_d = SUB;
         SUB:  state_d = SQX;
         SQX:  state_d = SQY;
`ifdef DIST_SQRT_EN
         SQY:  state_d = SQRT;
         SQRT: if (cnt_q == 5'd0) state_d = IDLE;
`else
         SQY:  state_d = WB;
`endif
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy    = (state_q != IDLE);
      mulSelY = (state_q == SQY);
   end

   // Computation datapath plus sticky DONE/OVF status
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         snapA_q  <= 32'd0;
         snapB_q  <= 32'd0;
         dx_q     <= 17'd0;
         dy_q     <= 17'd0;
         sqX_q    <= 32'd0;
         result_q <= 32'd0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef DIST_SQRT_EN
         rad_q    <= 34'd0;
         rem_q    <= 20'd0;
         root_q   <= 17'd0;
         cnt_q    <= 5'd0;
`else
         sum_q    <= 33'd0;
`endif
      end else begin
         if (startReq) begin
            snapA_q <= pa_q;
            snapB_q <= pb_q;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
         end else if (doneClr) begin
            done_q  <= 1'b0;
         end
         case (state_q)
            SUB: begin
               dx_q <= {snapA_q[15], snapA_q[15:0]}  - {snapB_q[15], snapB_q[15:0]};
               dy_q <= {snapA_q[31], snapA_q[31:16]} - {snapB_q[31], snapB_q[31:16]};
            end
            SQX: sqX_q <= sqr;
`ifdef DIST_SQRT_EN
            SQY: begin
               rad_q  <= {1'b0, sumNext};
               rem_q  <= 20'd0;
               root_q <= 17'd0;
               cnt_q  <= 5'd16;
            end
            SQRT: begin
               rad_q  <= {rad_q[31:0], 2'b00};
               rem_q  <= remNext;
               root_q <= rootNext;
               cnt_q  <= cnt_q - 5'd1;
               if (cnt_q == 5'd0) begin
                  result_q <= {15'd0, rootNext};
                  done_q   <= 1'b1;
               end
            end
`else
            SQY: sum_q <= sumNext;
            WB: begin
               if (sum_q[32]) begin
                  result_q <= 32'hFFFF_FFFF;
                  ovf_q    <= 1'b1;
               end else begin
                  result_q <= sum_q[31:0];
               end
               done_q <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dist_euclid_axil_slave.sv
// tb_dist_euclid_axil_slave: directed AXI4-Lite bench with a response scoreboard.
// Stimulus tasks push expected read data / write responses; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dist_euclid_axil_slave;

`ifdef DIST_SQRT_EN
   localparam int          LAT   = 20;
   localparam logic [31:0] RES1  = 32'h0000_0005;
   localparam logic [31:0] RES2  = 32'h0001_6A08;
   localparam logic [31:0] CTRL3 = 32'h0000_0002;
`else
   localparam int          LAT   = 4;
   localparam logic [31:0] RES1  = 32'h0000_0019;
   localparam logic [31:0] RES2  = 32'hFFFF_FFFF;
   localparam logic [31:0] CTRL3 = 32'h0000_000A;
`endif

   logic        clk = 1'b0;
   logic        rstN;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready, irq;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] expRdQ[$];
   logic [1:0]  expBQ[$];

   always #5 clk = ~clk;

   dist_euclid_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rstN),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .irq(irq)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout expected=handshake", name);
   endtask

   // Scoreboard monitor: every completed R or B beat is compared with the oldest expectation
   always @(negedge clk) begin
      logic [31:0] e;
      logic [1:0]  eb;
      if (rvalid && rready) begin
         if (expRdQ.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL unexpected_r actual=0x%08h expected=no_beat", rdata);
         end else begin
            e = expRdQ.pop_front();
            checkOutput("rdata", rdata, e);
            checkOutput("rresp", 32'(rresp), 32'd0);
         end
      end
      if (bvalid && bready) begin
         if (expBQ.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL unexpected_b actual=0x%0h expected=no_beat", bresp);
         end else begin
            eb = expBQ.pop_front();
            checkOutput("bresp", 32'(bresp), 32'(eb));
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit got;
      got = 1'b0;
      expBQ.push_back(2'b00);
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (awready) got = 1'b1;
      end
      if (!got) timeoutFail("aw_handshake");
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axiRead(input logic [3:0] addr, input logic [31:0] expected);
      bit got;
      got = 1'b0;
      expRdQ.push_back(expected);
      araddr = addr; arvalid = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (arready) got = 1'b1;
      end
      if (!got) timeoutFail("ar_handshake");
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic waitIdle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 40 && !idle; i++) begin
         @(negedge clk);
         if (!rvalid && !bvalid) idle = 1'b1;
      end
      if (!idle) timeoutFail("channels_idle");
      @(posedge clk); #1;
   endtask

   // Watches irq from the START edge: low one cycle before the latency, high at it, one rise in total
   task automatic irqWatch();
      int   rises;
      logic prev;
      rises = 0;
      prev  = irq;
      for (int k = 1; k <= LAT + 10; k++) begin
         @(posedge clk); #1;
         if (k == LAT - 1) checkOutput("irq_before_done", 32'(irq), 32'd0);
         if (k == LAT)     checkOutput("irq_at_done", 32'(irq), 32'd1);
         if (irq && !prev) rises++;
         prev = irq;
      end
      checkOutput("single_done", 32'(rises), 32'd1);
   endtask

   task automatic checkAllOutputsZero(input string tag);
      checkOutput({tag, "_awready"}, 32'(awready), 32'd0);
      checkOutput({tag, "_wready"},  32'(wready),  32'd0);
      checkOutput({tag, "_bvalid"},  32'(bvalid),  32'd0);
      checkOutput({tag, "_arready"}, 32'(arready), 32'd0);
      checkOutput({tag, "_rvalid"},  32'(rvalid),  32'd0);
      checkOutput({tag, "_rdata"},   rdata,        32'd0);
      checkOutput({tag, "_irq"},     32'(irq),     32'd0);
   endtask

   // Full directed sequence
   task automatic applyStimulus();
      bit got;
      // Reset state and zeroed register map
      @(negedge clk);
      checkAllOutputsZero("rst_hold");
      wait ($time >= 200);
      rstN = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checkAllOutputsZero("rst_release");
      @(posedge clk); #1;
      axiRead(4'h0, 32'h0); axiRead(4'h4, 32'h0); axiRead(4'h8, 32'h0); axiRead(4'hC, 32'h0);
      waitIdle();

      // 3-4-5 triangle with IE set, then with IE clear
      axiWrite(4'h0, 32'h0004_0003, 4'hF);
      axiWrite(4'h4, 32'h0000_0000, 4'hF);
      axiWrite(4'h8, 32'h0000_0011, 4'hF);
      irqWatch();
      waitIdle();
      axiRead(4'h8, 32'h0000_0012);
      axiRead(4'hC, RES1);
      axiWrite(4'h8, 32'h0000_0002, 4'hF);
      waitIdle();
      checkOutput("irq_after_clear", 32'(irq), 32'd0);
      axiRead(4'h8, 32'h0000_0000);
      axiWrite(4'h8, 32'h0000_0001, 4'hF);
      waitCycles(LAT + 2);
      checkOutput("irq_masked", 32'(irq), 32'd0);
      axiRead(4'h8, 32'h0000_0002);
      waitIdle();

      // Extreme points; DONE clear and START in the same write
      axiWrite(4'h0, 32'h8000_8000, 4'hF);
      axiWrite(4'h4, 32'h7FFF_7FFF, 4'hF);
      axiWrite(4'h8, 32'h0000_0003, 4'hF);
      waitCycles(LAT + 2);
      axiRead(4'h8, CTRL3);
      axiRead(4'hC, RES2);
      waitIdle();

      // Byte strobes and read-only RESULT
      axiWrite(4'h0, 32'h0000_0000, 4'hF);
      axiWrite(4'h0, 32'hAABB_CCDD, 4'b0010);
      axiRead(4'h0, 32'h0000_CC00);
      axiWrite(4'hC, 32'h1234_5678, 4'hF);
      axiRead(4'hC, RES2);
      waitIdle();

      // AW ahead of W, then B backpressure with a second write pending
      bready = 1'b0;
      awaddr = 4'h4; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("aw_wait_awready", 32'(awready), 32'd0);
         checkOutput("aw_wait_wready",  32'(wready),  32'd0);
      end
      @(posedge clk); #1;
      wvalid = 1'b1;
      expBQ.push_back(2'b00);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (awready) got = 1'b1;
      end
      if (!got) timeoutFail("aw_late_w");
      checkOutput("aw_w_together", 32'(wready), 32'd1);
      @(posedge clk); #1;
      wdata = 32'h3333_4444;
      expBQ.push_back(2'b00);
      repeat (5) begin
         @(negedge clk);
         checkOutput("b_hold_bvalid", 32'(bvalid), 32'd1);
         checkOutput("b_hold_no_accept", 32'(awready), 32'd0);
      end
      @(posedge clk); #1;
      bready = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (awready) got = 1'b1;
      end
      if (!got) timeoutFail("aw_second");
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      waitIdle();
      axiRead(4'h4, 32'h3333_4444);
      waitIdle();

      // R backpressure keeps RDATA stable
      rready = 1'b0;
      axiRead(4'h0, 32'h0000_CC00);
      repeat (4) begin
         @(negedge clk);
         checkOutput("r_hold_rvalid", 32'(rvalid), 32'd1);
         checkOutput("r_hold_rdata", rdata, 32'h0000_CC00);
      end
      @(posedge clk); #1;
      rready = 1'b1;
      waitIdle();

      // Same-cycle read and write of PA: read sees the old value
      fork
         axiWrite(4'h0, 32'h0004_0003, 4'hF);
         axiRead(4'h0, 32'h0000_CC00);
      join
      waitIdle();
      axiRead(4'h0, 32'h0004_0003);
      axiWrite(4'h4, 32'h0000_0000, 4'hF);
      waitIdle();

      // PA rewritten while busy: result follows the snapshot
      axiWrite(4'h8, 32'h0000_0011, 4'hF);
      fork
         axiWrite(4'h0, 32'h0000_0000, 4'hF);
         irqWatch();
      join
      waitIdle();
      axiRead(4'hC, RES1);
      axiRead(4'h0, 32'h0000_0000);
      waitIdle();

      // Second START while busy is ignored
      axiWrite(4'h0, 32'h0004_0003, 4'hF);
      axiWrite(4'h8, 32'h0000_0011, 4'hF);
      fork
         axiWrite(4'h8, 32'h0000_0011, 4'hF);
         irqWatch();
      join
      waitIdle();
      axiRead(4'hC, RES1);
      axiRead(4'h8, 32'h0000_0012);
      waitIdle();

      // Reset two cycles into a computation aborts it
      axiWrite(4'h8, 32'h0000_0011, 4'hF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstN = 1'b0;
      @(negedge clk);
      checkAllOutputsZero("rst_mid");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk); #1;
      waitCycles(LAT + 2);
      checkOutput("irq_after_abort", 32'(irq), 32'd0);
      axiRead(4'h8, 32'h0000_0000);
      axiRead(4'hC, 32'h0000_0000);
      axiRead(4'h0, 32'h0000_0000);
      waitIdle();
   endtask

   initial begin
      rstN = 1'b0;
      awaddr = 4'h0; awprot = 3'b000; awvalid = 1'b0;
      wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1;
      araddr = 4'h0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;
      applyStimulus();
      checkOutput("sb_drained_r", 32'(expRdQ.size()), 32'd0);
      checkOutput("sb_drained_b", 32'(expBQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
